// File: rtl/fp32_accumulator.sv
// Frame-based fp32 accumulator: sums a stream of products into one fp32 result
// through a multi-cycle align / add / iterative-normalize datapath.
module fp32_accumulator #(
  parameter int unsigned GUARD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  localparam int unsigned MW = 24 + GUARD_BITS;  // aligned mantissa width
  localparam int unsigned EW = 9;                // exponent with overflow headroom

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} stateType;
  stateType state, stateNext;

  logic [31:0]   acc, accNext, term, termNext, outData, outDataNext;
  logic          first, firstNext, last, lastNext;
  logic          inReady, inReadyNext, outValid, outValidNext, busyR, busyNext;
  logic [EW-1:0] expR, expNext;
  logic [MW-1:0] manA, manANext, manB, manBNext;
  logic          signA, signANext, signB, signBNext;
  logic [MW:0]   sum, sumNext;
  logic          sumSign, sumSignNext;

  logic [7:0]    termExp, accExp, expDiff;
  logic [MW-1:0] termMan, accMan, smallMan, smallShifted;
  logic          termGe;
  logic          normDone;
  logic [31:0]   normResult;
  logic [EW-1:0] expOut;
  logic [22:0]   manOut;

  // Operand decode and alignment shifter (exp==0 flushes to a zero mantissa)
  assign termExp      = term[30:23];
  assign accExp       = acc[30:23];
  assign termMan      = (termExp != 8'd0) ? {1'b1, term[22:0], {GUARD_BITS{1'b0}}} : '0;
  assign accMan       = (accExp != 8'd0) ? {1'b1, acc[22:0], {GUARD_BITS{1'b0}}} : '0;
  assign termGe       = termExp >= accExp;
  assign expDiff      = termGe ? (termExp - accExp) : (accExp - termExp);
  assign smallMan     = termGe ? accMan : termMan;
  assign smallShifted = (expDiff >= 8'(MW)) ? '0 : (smallMan >> expDiff);

  always_comb begin
    stateNext    = state;
    accNext      = acc;
    termNext     = term;
    outDataNext  = outData;
    firstNext    = first;
    lastNext     = last;
    inReadyNext  = inReady;
    outValidNext = outValid;
    busyNext     = busyR;
    expNext      = expR;
    manANext     = manA;
    manBNext     = manB;
    signANext    = signA;
    signBNext    = signB;
    sumNext      = sum;
    sumSignNext  = sumSign;
    normDone     = 1'b0;
    normResult   = '0;
    expOut       = expR;
    manOut       = '0;

    case (state)
      IDLE: begin
        if (in_valid && inReady) begin
          termNext    = in_data;
          lastNext    = in_last;
          inReadyNext = 1'b0;
          busyNext    = 1'b1;
          stateNext   = ALIGN;
        end
      end

      ALIGN: begin
        if (first) begin
          expNext   = {1'b0, termExp};
          manANext  = termMan;
          signANext = term[31];
          manBNext  = '0;
          signBNext = 1'b0;
        end else begin
          expNext   = termGe ? {1'b0, termExp} : {1'b0, accExp};
          manANext  = termGe ? termMan : accMan;
          signANext = termGe ? term[31] : acc[31];
          manBNext  = smallShifted;
          signBNext = termGe ? acc[31] : term[31];
        end
        stateNext = ADD;
      end

      ADD: begin
        if (signA == signB) begin
          sumNext     = {1'b0, manA} + {1'b0, manB};
          sumSignNext = signA;
        end else if (manA >= manB) begin
          sumNext     = {1'b0, manA - manB};
          sumSignNext = signA;
        end else begin
          sumNext     = {1'b0, manB - manA};
          sumSignNext = signB;
        end
        stateNext = NORM;
      end

      NORM: begin
        if (sum == '0) begin
          normDone = 1'b1;
        end else if (sum[MW] || sum[MW-1]) begin
          normDone = 1'b1;
          expOut   = sum[MW] ? (expR + EW'(1)) : expR;
          manOut   = sum[MW] ? sum[MW-1:GUARD_BITS+1] : sum[MW-2:GUARD_BITS];
          if (expOut >= EW'(255))
            normResult = {sumSign, 8'hFF, 23'd0};
          else if (expOut != '0)
            normResult = {sumSign, expOut[7:0], manOut};
        end else if (expR <= EW'(1)) begin
          // one more left shift would underflow the exponent: flush to +0
          normDone = 1'b1;
        end else begin
          sumNext = sum << 1;
          expNext = expR - EW'(1);
        end
        if (normDone) begin
          accNext   = normResult;
          firstNext = 1'b0;
          if (last) begin
            stateNext = OUT;
          end else begin
            stateNext   = IDLE;
            inReadyNext = 1'b1;
          end
        end
      end

      OUT: begin
        if (!outValid) begin
          outDataNext  = acc;
          outValidNext = 1'b1;
        end else if (out_ready) begin
          outValidNext = 1'b0;
          busyNext     = 1'b0;
          accNext      = '0;
          firstNext    = 1'b1;
          inReadyNext  = 1'b1;
          stateNext    = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      term     <= '0;
      outData  <= '0;
      first    <= 1'b1;
      last     <= 1'b0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busyR    <= 1'b0;
      expR     <= '0;
      manA     <= '0;
      manB     <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      sum      <= '0;
      sumSign  <= 1'b0;
    end else begin
      state    <= stateNext;
      acc      <= accNext;
      term     <= termNext;
      outData  <= outDataNext;
      first    <= firstNext;
      last     <= lastNext;
      inReady  <= inReadyNext;
      outValid <= outValidNext;
      busyR    <= busyNext;
      expR     <= expNext;
      manA     <= manANext;
      manB     <= manBNext;
      signA    <= signANext;
      signB    <= signBNext;
      sum      <= sumNext;
      sumSign  <= sumSignNext;
    end
  end

  assign in_ready  = inReady;
  assign out_data  = outData;
  assign out_valid = outValid;
  assign busy      = busyR;

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed bench for fp32_accumulator: arithmetic reference model checked every
// cycle out_valid is high, plus hand-computed sums, latencies and handshake checks.
`timescale 1ns/1ps
module tb_fp32_accumulator;
  localparam int unsigned GB = 3;
  localparam int MW = 24 + GB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int          nCompared = 0;
  int          nMismatch = 0;
  bit          simDone = 1'b0;
  logic [31:0] mAcc;
  logic [31:0] expQ[$];

  fp32_accumulator #(.GUARD_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: acc + term with truncating arithmetic on scaled integers
  function automatic logic [31:0] fpSum(input logic [31:0] x, input logic [31:0] y);
    longint mx, my, s, mag;
    int     ex, ey, e, p, need;
    bit     neg;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'sd0 : (longint'({1'b1, x[22:0]}) << GB);
    my = (ey == 0) ? 64'sd0 : (longint'({1'b1, y[22:0]}) << GB);
    if (ex >= ey) begin
      e  = ex;
      my = (ex - ey >= MW) ? 64'sd0 : (my >> (ex - ey));
    end else begin
      e  = ey;
      mx = (ey - ex >= MW) ? 64'sd0 : (mx >> (ey - ex));
    end
    s = (x[31] ? -mx : mx) + (y[31] ? -my : my);
    if (s == 0) return 32'h0;
    neg = (s < 0);
    mag = neg ? -s : s;
    p = -1;
    for (int i = 0; i <= MW; i++) if (mag[i]) p = i;
    if (p == MW) begin
      e   = e + 1;
      mag = mag >> 1;
      if (e >= 255) return {neg, 8'hFF, 23'd0};
    end else begin
      need = (MW - 1) - p;
      if (need >= e) return 32'h0;
      e   = e - need;
      mag = mag << need;
    end
    return {neg, 8'(e), 23'(mag >> GB)};
  endfunction

  // Present one term; optionally measure edges from accept to in_ready (or out_valid if last)
  task automatic sendTerm(input logic [31:0] d, input logic l, input int expLat, input string name);
    int n;
    bit sawReady;
    @(posedge clk); #1;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check({name, " accept timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expLat >= 0) begin
      n = 0;
      sawReady = 1'b0;
      do begin
        @(negedge clk);
        n++;
        if (l && in_ready) sawReady = 1'b1;
      end while (!(l ? out_valid : in_ready) && n < 200);
      check({name, " latency"}, 32'(n - 1), 32'(expLat));
      if (l) check({name, " in_ready low while computing"}, 32'(sawReady), 32'd0);
    end
  endtask

  // Called at the negedge where out_valid is seen with out_ready=1
  task automatic finishFrame(input string name);
    @(negedge clk);
    check({name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    check({name, " busy after handoff"}, 32'(busy), 32'd0);
    check({name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  task automatic monitor();
    while (!simDone) begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (expQ.size() == 0) check("out_valid with no frame expected", 32'(out_valid), 32'd0);
          else check("out_data vs model", out_data, expQ[0]);
          if (out_ready && expQ.size() != 0) void'(expQ.pop_front());
        end
        if (in_valid && in_ready) begin
          mAcc = fpSum(mAcc, in_data);
          if (in_last) begin
            expQ.push_back(mAcc);
            mAcc = 32'h0;
          end
        end
      end
    end
  endtask

  task automatic directed();
    sendTerm(32'h3FC00000, 1'b0, 3, "t1a");
    check("busy mid-frame", 32'(busy), 32'd1);
    sendTerm(32'h40200000, 1'b1, 4, "t1b");
    check("1.5+2.5", out_data, 32'h40800000);
    finishFrame("t1");

    sendTerm(32'h3F800000, 1'b0, 3, "t2a");
    sendTerm(32'h40000000, 1'b0, 3, "t2b");
    sendTerm(32'h40400000, 1'b1, 4, "t2c");
    check("1+2+3", out_data, 32'h40C00000);
    finishFrame("t2");

    sendTerm(32'h3F800000, 1'b0, 3, "t3a");
    sendTerm(32'hBF800000, 1'b1, 4, "t3b");
    check("1-1 cancel", out_data, 32'h00000000);
    finishFrame("t3");

    sendTerm(32'h3F800000, 1'b0, 3, "t4a");
    sendTerm(32'hBF7FFFFF, 1'b1, 28, "t4b");
    check("deep normalize", out_data, 32'h33800000);
    finishFrame("t4");

    sendTerm(32'h40A00000, 1'b0, 3, "t5a");
    sendTerm(32'hBF400000, 1'b1, 4, "t5b");
    check("5-0.75", out_data, 32'h40880000);
    finishFrame("t5");

    sendTerm(32'h3F800000, 1'b0, 3, "t6a");
    sendTerm(32'h30800000, 1'b1, 4, "t6b");
    check("1+2^-30 shifted out", out_data, 32'h3F800000);
    finishFrame("t6");

    sendTerm(32'h00400000, 1'b1, 4, "t7");
    check("denormal single term", out_data, 32'h00000000);
    finishFrame("t7");

    @(posedge clk); #1;
    out_ready = 1'b0;
    sendTerm(32'h7F7FFFFF, 1'b0, 3, "t8a");
    sendTerm(32'h7F7FFFFF, 1'b1, 4, "t8b");
    check("overflow to inf", out_data, 32'h7F800000);
    repeat (5) begin
      @(negedge clk);
      check("backpressure out_valid held", 32'(out_valid), 32'd1);
      check("backpressure out_data held", out_data, 32'h7F800000);
      check("backpressure in_ready low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    finishFrame("t8");

    sendTerm(32'h3F800000, 1'b0, 3, "t9a");
    sendTerm(32'hBF7FFFFF, 1'b1, -1, "t9b");
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-NORM reset in_ready", 32'(in_ready), 32'd1);
    check("mid-NORM reset out_valid", 32'(out_valid), 32'd0);
    check("mid-NORM reset out_data", out_data, 32'h0);
    check("mid-NORM reset busy", 32'(busy), 32'd0);
    mAcc = 32'h0;
    expQ.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;

    sendTerm(32'h40000000, 1'b1, 4, "t10");
    check("single term after reset", out_data, 32'h40000000);
    finishFrame("t10");

    check("model queue drained", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    simDone = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    mAcc      = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    fork
      monitor();
      directed();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/fp32_accumulator.md
Name: fp32_accumulator

Overview:
- Downstream consumer of the single-precision multiplier outputs in the FPGA datapath.
- Sums a framed stream of IEEE-754 fp32 products into one fp32 result, which closes the multiply-accumulate (dot-product) path.
- Multi-cycle datapath: align, add and iterative normalize, controlled by an FSM, with valid/ready handshakes on input and output.

Parameters:
- GUARD_BITS, 3, extra low-order mantissa bits carried through align/add/normalize; dropped (truncated) on write-back.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  32  fp32 term {sign, exp[7:0], man[22:0]}.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  marks final term of current frame.
- in_ready  output  1  block accepts a term this cycle.
- out_data  output  32  fp32 frame sum.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  frame in progress (at least one term accepted, result not yet handed off).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=+0, first=1, out_data=0, out_valid=0, in_ready=1, busy=0. Reset mid-frame discards all partial state.
- Number handling: exp==0 is treated as zero (denormal flush). exp==255 inputs are not supported (undefined). Mantissa is {1,man} when exp!=0, else 0. Rounding is truncation throughout.
- States: IDLE, ALIGN, ADD, NORM, OUT. All outputs are registered.
- IDLE: in_ready=1. A transfer occurs on in_valid&&in_ready. It latches the term and the last flag, then goes to ALIGN with in_ready=0 and busy=1.
- ALIGN (1 cycle):
  - If first=1, the operand pair is (term, +0).
  - Otherwise the larger exponent is kept. The smaller-exponent mantissa, extended to 24+GUARD_BITS bits, is right-shifted by the exponent difference. A difference ≥ 24+GUARD_BITS makes it 0.
- ADD (1 cycle):
  - Same signs: the magnitudes are added into a 25+GUARD_BITS-bit sum.
  - Different signs: the smaller magnitude is subtracted from the larger, and the result takes the sign of the larger.
  - Equal magnitudes with opposite signs give +0.
- NORM (1 cycle per step):
  - Sum==0: acc=+0, done.
  - Carry bit set: shift right 1, exp+1, done.
  - MSB clear: shift left 1, exp-1, repeat. Worst case is 24+GUARD_BITS-1 shift cycles.
  - Normalized: done.
  - Exponent ≥255 gives ±Inf (exp=255, man=0).
  - Exponent reaching 0 gives +0 (flush).
  - On done, acc is written with man = bits below the hidden bit, guard bits dropped, and first is cleared. The next state is OUT if last, else IDLE.
- Latency: term accept → in_ready high again = 3 + (number of left shifts) cycles.
- OUT: out_data=acc, out_valid=1, in_ready=0.
  - While out_ready=0, out_data stays stable and out_valid stays high (no drop).
  - On out_ready=1: out_valid=0, busy=0, acc=+0, first=1, next state IDLE.
- Single-term frame (first term has in_last=1): out_data equals the input, or +0 if that input has exp==0.
- in_valid while in_ready=0 is ignored. The upstream must hold the term.

Test Plan:
- Two-term frame: 0x3FC00000 then 0x40200000 (last) → out_data=0x40800000 (4.0), 4 cycles from the second accept to out_valid.
- Three terms 0x3F800000, 0x40000000, 0x40400000 (last) → 0x40C00000 (6.0). in_ready is low during each compute.
- Cancellation: 0x3F800000 then 0xBF800000 (last) → 0x00000000.
- Deep normalize: 0x3F800000 then 0xBF7FFFFF (last) → 0x33800000 (2^-24). NORM takes 24 shift cycles plus 1.
- Overflow plus backpressure: 0x7F7FFFFF twice (last) → 0x7F800000. With out_ready held 0 for 5 cycles, out_valid and out_data stay stable and in_ready stays 0. Accepted on out_ready=1.
- Reset mid-NORM during the deep-normalize case: assert rst_n=0 → outputs immediately at reset values. After release, frame 0x40000000 (last) → 0x40000000.
